// File: rtl/dna_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dna_pkg
// Purpose : Shared types for the DNA scan arbiter: nucleotide codes, FSM
//           state encoding, result counter width and a saturating increment.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package dna_pkg;

  typedef enum logic [1:0] {
    NUC_A = 2'b00,
    NUC_T = 2'b01,
    NUC_C = 2'b10,
    NUC_G = 2'b11
  } nuc_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

endpackage : dna_pkg
`default_nettype wire

// File: rtl/dna_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : dna_rr_arb
// Purpose : Two-way round-robin grant. With both requests active the
//           requester not granted last wins; with one active, it wins.
// Ports   : req0_i, req1_i   - request lines
//           last_grant_i     - index granted previously
//           grant_o          - index granted now (0 when no request)
// Revision: 1.0 - initial release
// ============================================================================
module dna_rr_arb (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_o
);

  always_comb begin
    grant_o = 1'b0;
    if (req0_i && req1_i) begin
      grant_o = ~last_grant_i;
    end else if (req1_i) begin
      grant_o = 1'b1;
    end
  end

endmodule : dna_rr_arb
`default_nettype wire

// File: rtl/dna_scan_arb.sv
`default_nettype none
// ============================================================================
// Module  : dna_scan_arb
// Purpose : Arbitrates two nucleotide burst requesters onto one shared
//           spaced-pattern detector, counts beats and detector hits per
//           burst and reports them through a valid/ready result port.
// Ports   : clk, rst                      - clock, async active-high reset
//           reqN_valid/x/last, reqN_ready - requester beat handshakes
//           det_x/det_en/det_clr, det_y   - detector drive and hit flag
//           res_valid/ready/id/len/hits   - per-burst result
//           busy                          - FSM not idle
// Revision: 1.0 - initial release
// ============================================================================
module dna_scan_arb
  import dna_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [1:0]       req0_x,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_x,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic [1:0]       det_x,
  output logic             det_en,
  output logic             det_clr,
  input  logic             det_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [CNT_W-1:0] res_len,
  output logic [CNT_W-1:0] res_hits,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] len_q, hits_q;
  logic             en_prev_q;
  logic             arb_grant;
  logic             sel_valid, sel_last;
  logic [1:0]       sel_x;
  logic             hit_count;

  dna_rr_arb u_arb (
    .req0_i      (req0_valid),
    .req1_i      (req1_valid),
    .last_grant_i(last_grant_q),
    .grant_o     (arb_grant)
  );

  // Beat signals of whichever requester owns the current burst.
  assign sel_valid = grant_q ? req1_valid : req0_valid;
  assign sel_x     = grant_q ? req1_x     : req0_x;
  assign sel_last  = grant_q ? req1_last  : req0_last;

  // det_y answers the det_en beat of the previous cycle; DRAIN exists so
  // the answer to the final beat still lands here.
  assign hit_count = det_y && en_prev_q &&
                     ((state_q == ST_STREAM) || (state_q == ST_DRAIN));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    det_x        = NUC_A;
    det_en       = 1'b0;
    det_clr      = 1'b0;
    res_valid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d = arb_grant;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        det_clr = 1'b1;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        req0_ready = ~grant_q;
        req1_ready = grant_q;
        det_x      = sel_x;
        det_en     = sel_valid;
        if (sel_valid && sel_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_REPORT;
      end
      ST_REPORT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      len_q        <= '0;
      hits_q       <= '0;
      en_prev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      en_prev_q    <= det_en;
      if (state_q == ST_CLEAR) begin
        len_q  <= '0;
        hits_q <= '0;
      end else begin
        if (det_en)    len_q  <= sat_inc(len_q);
        if (hit_count) hits_q <= sat_inc(hits_q);
      end
    end
  end

  assign res_id   = grant_q;
  assign res_len  = len_q;
  assign res_hits = hits_q;
  assign busy     = (state_q != ST_IDLE);

endmodule : dna_scan_arb
`default_nettype wire

// File: tb/tb_dna_scan_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_dna_scan_arb
// Purpose : Self-checking bench for dna_scan_arb. Directed bursts push their
//           hand-computed results into a queue; a monitor pops and compares
//           on every accepted result. A small detector stub drives det_y.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dna_scan_arb;

  localparam int LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0] req0_x = 2'b00, req1_x = 2'b00;
  logic       req0_last = 1'b0, req1_last = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] det_x;
  logic       det_en, det_clr;
  logic       det_y;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic       res_id;
  logic [7:0] res_len, res_hits;
  logic       busy;

  dna_scan_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_last(req1_last), .req1_ready(req1_ready),
    .det_x(det_x), .det_en(det_en), .det_clr(det_clr), .det_y(det_y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_len(res_len), .res_hits(res_hits), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic id; logic [7:0] len; logic [7:0] hits; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // C,G,A,T,T,C,G,C,C
  logic [1:0] pat9 [9] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10};

  // Detector stub: 0 = never hits, 1 = hits every beat, 2 = beats 4 and 9.
  int hit_mode = 0;
  int beat_cnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      det_y    <= 1'b0;
      beat_cnt <= 0;
    end else begin
      if (det_clr)     beat_cnt <= 0;
      else if (det_en) beat_cnt <= beat_cnt + 1;
      det_y <= det_en && ((hit_mode == 1) ||
               ((hit_mode == 2) && ((beat_cnt + 1 == 4) || (beat_cnt + 1 == 9))));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: scoreboard pops, mutual-exclusion of ready, det_x capture.
  logic [1:0] cap[$];
  bit         cap_on = 1'b0;
  int         clr_cnt = 0;
  int         clr_at_first = -1;

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_mutex", 32'(req0_ready & req1_ready), 0);
      if (det_clr) clr_cnt++;
      if (cap_on && det_en) begin
        if (cap.size() == 0) clr_at_first = clr_cnt;
        cap.push_back(det_x);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got id=%0d len=%0d hits=%0d expected none",
                   res_id, res_len, res_hits);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("res_id", 32'(res_id), 32'(e.id));
          chk("res_len", 32'(res_len), 32'(e.len));
          chk("res_hits", 32'(res_hits), 32'(e.hits));
        end
      end
    end
  end

  task automatic drive(input logic id, input logic v, input logic [1:0] x, input logic l);
    if (id) begin
      req1_valid = v; req1_x = x; req1_last = l;
    end else begin
      req0_valid = v; req0_x = x; req0_last = l;
    end
  endtask

  function automatic logic rdy(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction

  // Send an n-beat burst; optional one-cycle valid gap after beat gap_at.
  task automatic send(input logic id, input int n, input bit use_pat, input int gap_at);
    int guard;
    for (int i = 0; i < n; i++) begin
      drive(id, 1'b1, use_pat ? pat9[i % 9] : 2'(i), (i == n - 1));
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!rdy(id) && guard < LIMIT);
      if (!rdy(id)) begin
        fail("beat_accept");
        drive(id, 1'b0, 2'b00, 1'b0);
        return;
      end
      @(posedge clk);
      #1;
      if (gap_at == i + 1 && i != n - 1) begin
        drive(id, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        chk("gap_det_en", 32'(det_en), 0);
        @(posedge clk);
        #1;
      end
    end
    drive(id, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic wait_done();
    int guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 5 * LIMIT) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0 || busy) fail("wait_done");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res_valid();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!res_valid && guard < LIMIT);
    if (!res_valid) fail("res_valid_wait");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while rst is held.
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_ready1", 32'(req1_ready), 0);
    chk("rst_det_en", 32'(det_en), 0);
    chk("rst_det_clr", 32'(det_clr), 0);
    chk("rst_det_x", 32'(det_x), 0);
    chk("rst_res_len", 32'(res_len), 0);
    chk("rst_res_hits", 32'(res_hits), 0);
    chk("rst_res_id", 32'(res_id), 0);

    // Both valid at release: req0 first, then req1.
    drive(1'b0, 1'b1, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 2'b00, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back('{1'b0, 8'd3, 8'd0});
    exp_q.push_back('{1'b1, 8'd2, 8'd0});
    fork
      send(1'b0, 3, 1'b0, 0);
      send(1'b1, 2, 1'b0, 0);
    join
    wait_done();

    // 9-beat pattern burst from req0 with a gap after beat 2; hits on 4 and 9.
    hit_mode = 2;
    clr_cnt  = 0;
    cap.delete();
    cap_on   = 1'b1;
    exp_q.push_back('{1'b0, 8'd9, 8'd2});
    send(1'b0, 9, 1'b1, 2);
    wait_done();
    cap_on = 1'b0;
    chk("det_x_beats", cap.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < cap.size()) chk("det_x_seq", 32'(cap[i]), 32'(pat9[i]));
    end
    chk("clr_before_first", clr_at_first, 1);
    chk("clr_total", clr_cnt, 1);

    // req0 just finished; both valid -> req1 (single-beat burst, len=1).
    hit_mode = 0;
    exp_q.push_back('{1'b1, 8'd1, 8'd0});
    exp_q.push_back('{1'b0, 8'd2, 8'd0});
    fork
      send(1'b0, 2, 1'b0, 0);
      send(1'b1, 1, 1'b0, 0);
    join
    wait_done();

    // Result stall: res_ready low for 5 cycles with req1 pending.
    hit_mode  = 1;
    res_ready = 1'b0;
    exp_q.push_back('{1'b0, 8'd4, 8'd4});
    exp_q.push_back('{1'b1, 8'd1, 8'd1});
    fork
      send(1'b0, 4, 1'b0, 0);
      begin
        wait_res_valid();
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          chk("stall_valid", 32'(res_valid), 1);
          chk("stall_id", 32'(res_id), 0);
          chk("stall_len", 32'(res_len), 4);
          chk("stall_hits", 32'(res_hits), 4);
          chk("stall_det_clr", 32'(det_clr), 0);
          chk("stall_ready1", 32'(req1_ready), 0);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
      end
      begin
        wait_res_valid();
        send(1'b1, 1, 1'b0, 0);
      end
    join
    wait_done();

    // Reset after 3 accepted beats of a req1 burst.
    begin
      int acc = 0;
      int guard = 0;
      drive(1'b1, 1'b1, 2'b01, 1'b0);
      while (acc < 3 && guard < LIMIT) begin
        @(negedge clk);
        guard++;
        if (req1_ready) begin
          @(posedge clk);
          acc++;
        end
      end
      if (acc < 3) fail("abort_beats");
      #3 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_ready1", 32'(req1_ready), 0);
      chk("arst_det_en", 32'(det_en), 0);
      chk("arst_det_x", 32'(det_x), 0);
      chk("arst_res_valid", 32'(res_valid), 0);
      chk("arst_res_len", 32'(res_len), 0);
      drive(1'b1, 1'b0, 2'b00, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
    end
    hit_mode = 0;
    exp_q.push_back('{1'b0, 8'd2, 8'd0});
    send(1'b0, 2, 1'b0, 0);
    wait_done();

    // 300 beats, hit every beat: both counters saturate.
    hit_mode = 1;
    exp_q.push_back('{1'b0, 8'd255, 8'd255});
    send(1'b0, 300, 1'b0, 0);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dna_scan_arb
`default_nettype wire
